ins_queue_ctrl: RTL and testbench

Instruction queue and dispatch sequencer between the instruction fetcher and the decoder. Buffers fetched instructions with their branch-prediction tags in a circular FIFO, releases at most one per cycle into the decoder only when the reservation station, load/store buffer and ROB can all accept, and discards everything on a pipeline flush. It is the single point that throttles fetch and paces decode.

---
 rtl/ins_queue_if.sv | 37 +++
 rtl/ins_queue_ctrl.sv | 98 +++++++++
 tb/tb_ins_queue_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ins_queue_if.sv
// ins_queue_if: fetch-side and decode-side handshake bundle of the
// instruction queue.
//   fetch side : f_valid, f_ins, f_addr, f_pred_jmp, f_pred_another -> queue
//                q_full                                          <- queue
//   backpressure: rs_full, lsb_full, rob_full                     -> queue
//   decode side: d_is_ins, d_ins, d_addr, d_pred_jmp, d_pred_another <- queue
// modport slave is the queue, modport master is its environment.
interface ins_queue_if;
   logic        f_valid;
   logic [31:0] f_ins;
   logic [31:0] f_addr;
   logic        f_pred_jmp;
   logic [31:0] f_pred_another;
   logic        q_full;
   logic        rs_full;
   logic        lsb_full;
   logic        rob_full;
   logic        d_is_ins;
   logic [31:0] d_ins;
   logic [31:0] d_addr;
   logic        d_pred_jmp;
   logic [31:0] d_pred_another;

   modport slave (
      input  f_valid, f_ins, f_addr, f_pred_jmp, f_pred_another,
      input  rs_full, lsb_full, rob_full,
      output q_full,
      output d_is_ins, d_ins, d_addr, d_pred_jmp, d_pred_another
   );

   modport master (
      output f_valid, f_ins, f_addr, f_pred_jmp, f_pred_another,
      output rs_full, lsb_full, rob_full,
      input  q_full,
      input  d_is_ins, d_ins, d_addr, d_pred_jmp, d_pred_another
   );
endinterface

// File: rtl/ins_queue_ctrl.sv
// ins_queue_ctrl: circular instruction FIFO between fetch and decode.
// Buffers {ins, addr, pred_jmp, pred_another}, releases at most one entry
// per cycle when no downstream unit is full, and empties on flush.
// Ports:
//   clk_in    clock, all state on the rising edge
//   rst_n_in  asynchronous active-low reset
//   rdy_in    global enable; 0 freezes all state and blocks push/pop
//   flush_in  discard all entries at this edge
//   qif       fetch/backpressure/decode bundle (ins_queue_if.slave)
//   q_count   current occupancy (0..DEPTH)
module ins_queue_ctrl #(
   parameter int DEPTH = 8,
   parameter int SLACK = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   ins_queue_if.slave               qif,
   output logic [$clog2(DEPTH):0]   q_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   ins_mem     [DEPTH];
   logic [31:0]   addr_mem    [DEPTH];
   logic [31:0]   another_mem [DEPTH];
   logic          jmp_mem     [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          ovf_err;

   logic          stall;
   logic          is_empty;
   logic          is_full;
   logic          push;
   logic          pop;
   logic          drop;

   assign stall    = qif.rs_full | qif.lsb_full | qif.rob_full;
   assign is_empty = (q_count == '0);
   assign is_full  = (q_count == CW'(DEPTH));
   assign pop      = rdy_in & ~flush_in & ~stall & ~is_empty;
   assign push     = rdy_in & ~flush_in & qif.f_valid & ~is_full;
   // A fetch arriving at a full queue is lost; remember it for debug.
   assign drop     = rdy_in & ~flush_in & qif.f_valid & is_full;

   // Head entry is shown unconditionally; d_is_ins qualifies it.
   assign qif.d_is_ins       = pop;
   assign qif.d_ins          = ins_mem[head];
   assign qif.d_addr         = addr_mem[head];
   assign qif.d_pred_jmp     = jmp_mem[head];
   assign qif.d_pred_another = another_mem[head];

   // Threshold leaves SLACK entries for fetches already in flight.
   assign qif.q_full = (q_count >= CW'(DEPTH - SLACK));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head    <= '0;
         tail    <= '0;
         q_count <= '0;
         ovf_err <= 1'b0;
      end else begin
         if (drop) begin
            ovf_err <= 1'b1;
         end
         if (rdy_in && flush_in) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
         end else begin
            if (push) begin
               tail <= tail + AW'(1);
            end
            if (pop) begin
               head <= head + AW'(1);
            end
            case ({push, pop})
               2'b10:   q_count <= q_count + CW'(1);
               2'b01:   q_count <= q_count - CW'(1);
               default: q_count <= q_count;
            endcase
         end
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk_in) begin
      if (push) begin
         ins_mem[tail]     <= qif.f_ins;
         addr_mem[tail]    <= qif.f_addr;
         jmp_mem[tail]     <= qif.f_pred_jmp;
         another_mem[tail] <= qif.f_pred_another;
      end
   end
endmodule

// File: tb/tb_ins_queue_ctrl.sv
module tb_ins_queue_ctrl;
   logic       clk_in;
   logic       rst_n_in;
   logic       rdy_in;
   logic       flush_in;
   logic [3:0] q_count;

   int n_assert;
   int n_fail;

   ins_queue_if qif();

   ins_queue_ctrl #(.DEPTH(8), .SLACK(2)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .qif      (qif),
      .q_count  (q_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a);
      qif.f_valid        = v;
      qif.f_addr         = a;
      qif.f_ins          = a ^ 32'hA5A5_0000;
      qif.f_pred_jmp     = a[2];
      qif.f_pred_another = a + 32'h0000_8000;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] a);
      chk({tag, "_addr"}, qif.d_addr, a);
      chk({tag, "_ins"}, qif.d_ins, a ^ 32'hA5A5_0000);
      chk({tag, "_jmp"}, {31'd0, qif.d_pred_jmp}, {31'd0, a[2]});
      chk({tag, "_alt"}, qif.d_pred_another, a + 32'h0000_8000);
   endtask

   logic [31:0] exp_q[$];
   int          mcount;
   logic        exp_pop;
   int          pushed;
   bit          reached;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      qif.rs_full  = 1'b0;
      qif.lsb_full = 1'b0;
      qif.rob_full = 1'b0;
      drive(1'b0, 32'h0);

      // Reset state
      #2;
      chk("rst_count", {28'd0, q_count}, 32'd0);
      chk("rst_dis", {31'd0, qif.d_is_ins}, 32'd0);
      chk("rst_qfull", {31'd0, qif.q_full}, 32'd0);
      #10 rst_n_in = 1'b1;
      tick();

      // Fill 6 entries under stall
      qif.rob_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'(i * 4));
         #1;
         chk("fill_dis", {31'd0, qif.d_is_ins}, 32'd0);
         tick();
         chk("fill_count", {28'd0, q_count}, 32'(i + 1));
         if (i == 4) chk("fill5_qfull", {31'd0, qif.q_full}, 32'd0);
         if (i == 5) chk("fill6_qfull", {31'd0, qif.q_full}, 32'd1);
      end
      drive(1'b0, 32'h0);

      // Drain in order
      qif.rob_full = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("drain_dis", {31'd0, qif.d_is_ins}, 32'd1);
         chk_head("drain", 32'(i * 4));
         tick();
      end
      chk("drain_count", {28'd0, q_count}, 32'd0);
      chk("drain_dis_end", {31'd0, qif.d_is_ins}, 32'd0);

      // Stream 20 with concurrent push/pop, pointers wrap
      for (int k = 0; k <= 20; k++) begin
         drive(k < 20, 32'h1000 + 32'(k * 4));
         #1;
         chk("strm_dis", {31'd0, qif.d_is_ins}, (k > 0) ? 32'd1 : 32'd0);
         if (k > 0) chk_head("strm", 32'h1000 + 32'((k - 1) * 4));
         chk("strm_le1", {31'd0, q_count <= 4'd1}, 32'd1);
         tick();
      end
      drive(1'b0, 32'h0);
      chk("strm_count", {28'd0, q_count}, 32'd0);

      // Intermittent stall on rob_full
      mcount  = 0;
      pushed  = 0;
      reached = 1'b0;
      for (int c = 0; c < 30 && !reached; c++) begin
         qif.rob_full = c[0];
         drive(1'b1, 32'h2000 + 32'(pushed * 4));
         #1;
         exp_pop = !qif.rob_full && (mcount != 0);
         chk("ints_dis", {31'd0, qif.d_is_ins}, {31'd0, exp_pop});
         if (exp_pop) chk_head("ints", exp_q[0]);
         tick();
         exp_q.push_back(32'h2000 + 32'(pushed * 4));
         pushed++;
         mcount++;
         if (exp_pop) begin
            void'(exp_q.pop_front());
            mcount--;
         end
         chk("ints_count", {28'd0, q_count}, 32'(mcount));
         if (qif.q_full) reached = 1'b1;
      end
      chk("ints_reached_full", {31'd0, reached}, 32'd1);
      chk("ints_count_full", {28'd0, q_count}, 32'd6);
      drive(1'b0, 32'h0);
      qif.rob_full = 1'b0;
      chk("ints_ovf", {31'd0, dut.ovf_err}, 32'd0);
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
         #1;
         chk("ints_drain_dis", {31'd0, qif.d_is_ins}, 32'd1);
         chk_head("ints_drain", exp_q.pop_front());
         tick();
      end
      chk("ints_drain_count", {28'd0, q_count}, 32'd0);

      // Flush with simultaneous push
      qif.rob_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h3000 + 32'(i * 4));
         tick();
      end
      chk("fl_pre_count", {28'd0, q_count}, 32'd4);
      qif.rob_full = 1'b0;
      flush_in = 1'b1;
      drive(1'b1, 32'h100);
      #1;
      chk("fl_dis", {31'd0, qif.d_is_ins}, 32'd0);
      tick();
      flush_in = 1'b0;
      drive(1'b0, 32'h0);
      #1;
      chk("fl_count", {28'd0, q_count}, 32'd0);
      chk("fl_dis_after", {31'd0, qif.d_is_ins}, 32'd0);
      drive(1'b1, 32'h200);
      #1;
      chk("fl_nobypass", {31'd0, qif.d_is_ins}, 32'd0);
      tick();
      drive(1'b0, 32'h0);
      #1;
      chk("fl_pop_dis", {31'd0, qif.d_is_ins}, 32'd1);
      chk_head("fl_pop", 32'h200);
      tick();
      chk("fl_end_count", {28'd0, q_count}, 32'd0);
      chk("fl_end_dis", {31'd0, qif.d_is_ins}, 32'd0);

      // rdy_in hold, then asynchronous reset
      qif.rob_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4000 + 32'(i * 4));
         tick();
      end
      drive(1'b0, 32'h0);
      qif.rob_full = 1'b0;
      rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("hold_dis", {31'd0, qif.d_is_ins}, 32'd0);
         tick();
         chk("hold_count", {28'd0, q_count}, 32'd3);
      end
      rdy_in = 1'b1;
      #1;
      chk("pre_rst_dis", {31'd0, qif.d_is_ins}, 32'd1);
      chk_head("pre_rst", 32'h4000);
      #1;
      rst_n_in = 1'b0;
      #1;
      chk("arst_count", {28'd0, q_count}, 32'd0);
      chk("arst_dis", {31'd0, qif.d_is_ins}, 32'd0);
      chk("arst_qfull", {31'd0, qif.q_full}, 32'd0);
      chk("arst_ovf", {31'd0, dut.ovf_err}, 32'd0);
      #10 rst_n_in = 1'b1;
      tick();
      chk("post_rst_count", {28'd0, q_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
